ppu_phase_sequencer: RTL and testbench

Per-tile phase controller for the post-processing unit (PPU). It sequences channel-group compute, the partial-sum neighbor exchange, the drain of incoming neighbor writes and the final accumulation into OARAM. It also owns the PPU's single accumulation-buffer read port, granting it to the partial-exchange reader or the accumulator reader according to phase. It replaces the ad-hoc "all neighbors done" read-port steering with an explicit FSM, watchdog and status outputs.

---
 rtl/ppu_phase_sequencer_if.sv | 51 +++++
 rtl/ppu_phase_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_ppu_phase_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_phase_sequencer_if.sv
// Handshake and read-port bundle between the PPU datapath and its phase sequencer.
// The sequencer takes the slave side; the datapath (or a bench) takes the master side.
interface ppu_phase_sequencer_if #(
  parameter int BANK_COUNT   = 256,
  parameter int BUFFER_WIDTH = 256,
  parameter int NEIGHBORS    = 8
);
  localparam int BANK_W  = $clog2(BANK_COUNT);
  localparam int ENTRY_W = $clog2(BUFFER_WIDTH);

  logic                 start;
  logic [7:0]           channel_group_count;
  logic                 channel_group_done;
  logic                 exchange_done;
  logic [NEIGHBORS-1:0] neighbor_exchange_done;
  logic                 leftover_inputs;
  logic                 accumulate_done;

  logic                 part_req;
  logic [BANK_W-1:0]    part_bank;
  logic [ENTRY_W-1:0]   part_entry;
  logic                 acc_req;
  logic [BANK_W-1:0]    acc_bank;
  logic [ENTRY_W-1:0]   acc_entry;

  logic                 part_gnt;
  logic                 acc_gnt;
  logic [BANK_W-1:0]    buffer_bank_read;
  logic [ENTRY_W-1:0]   buffer_bank_entry;
  logic                 cg_done_out;
  logic                 acc_enable;
  logic [2:0]           phase;
  logic                 tile_done;
  logic                 error;

  modport master (
    output start, channel_group_count, channel_group_done, exchange_done,
           neighbor_exchange_done, leftover_inputs, accumulate_done,
           part_req, part_bank, part_entry, acc_req, acc_bank, acc_entry,
    input  part_gnt, acc_gnt, buffer_bank_read, buffer_bank_entry,
           cg_done_out, acc_enable, phase, tile_done, error
  );

  modport slave (
    input  start, channel_group_count, channel_group_done, exchange_done,
           neighbor_exchange_done, leftover_inputs, accumulate_done,
           part_req, part_bank, part_entry, acc_req, acc_bank, acc_entry,
    output part_gnt, acc_gnt, buffer_bank_read, buffer_bank_entry,
           cg_done_out, acc_enable, phase, tile_done, error
  );
endinterface

// File: rtl/ppu_phase_sequencer.sv
// Per-tile PPU phase sequencer: compute -> neighbor exchange -> settle -> accumulate,
// with a per-phase watchdog and phase-based ownership of the accumulation-buffer read port.
module ppu_phase_sequencer #(
  parameter int BANK_COUNT    = 256,
  parameter int BUFFER_WIDTH  = 256,
  parameter int NEIGHBORS     = 8,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,  // active-high; name shared with sibling blocks
  ppu_phase_sequencer_if.slave io_bus
);
  localparam int BANK_W   = $clog2(BANK_COUNT);
  localparam int ENTRY_W  = $clog2(BUFFER_WIDTH);
  localparam int STICKY_W = NEIGHBORS + 1;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_COMPUTE    = 3'd1;
  localparam logic [2:0] S_EXCHANGE   = 3'd2;
  localparam logic [2:0] S_SETTLE     = 3'd3;
  localparam logic [2:0] S_ACCUMULATE = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;
  localparam logic [2:0] S_ERROR      = 3'd6;

  // Expiry fires when the increment would land on the all-ones count.
  localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST = {{(TIMEOUT_WIDTH-1){1'b1}}, 1'b0};

  logic [2:0]               r_state;
  logic [7:0]               r_group_cnt;
  logic [STICKY_W-1:0]      r_sticky;
  logic [1:0]               r_settle_cnt;
  logic [TIMEOUT_WIDTH-1:0] r_wd;
  logic                     r_error;
  logic                     r_cg_done_out;
  logic [BANK_W-1:0]        r_hold_bank;
  logic [ENTRY_W-1:0]       r_hold_entry;

  logic [2:0]               w_state_next;
  logic [STICKY_W-1:0]      w_done_in;
  logic [STICKY_W-1:0]      w_sticky_seen;
  logic                     w_all_seen;
  logic                     w_accept_start;
  logic                     w_accept_cg;
  logic                     w_timed;
  logic                     w_wd_expire;
  logic                     w_state_change;
  logic                     w_part_gnt;
  logic                     w_acc_gnt;

  // Bit 0 is the local sender, bits 1..NEIGHBORS the neighbor PPUs.
  assign w_done_in[0] = io_bus.exchange_done;
  genvar gi;
  generate
    for (gi = 0; gi < NEIGHBORS; gi++) begin : g_nbr
      assign w_done_in[gi+1] = io_bus.neighbor_exchange_done[gi];
    end
  endgenerate

  assign w_sticky_seen  = r_sticky | w_done_in;
  assign w_all_seen     = &w_sticky_seen;
  assign w_accept_start = io_bus.start && (r_state == S_IDLE || r_state == S_ERROR);
  assign w_accept_cg    = io_bus.channel_group_done && (r_state == S_COMPUTE);
  assign w_timed        = (r_state == S_EXCHANGE) || (r_state == S_SETTLE) ||
                          (r_state == S_ACCUMULATE);
  assign w_wd_expire    = w_timed && (r_wd == WD_LAST);
  assign w_state_change = (w_state_next != r_state);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_ERROR: begin
        if (io_bus.start) begin
          w_state_next = (io_bus.channel_group_count == 8'd0) ? S_DONE : S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (io_bus.channel_group_done && r_group_cnt == 8'd1) begin
          w_state_next = S_EXCHANGE;
        end
      end
      S_EXCHANGE: begin
        if (w_all_seen) begin
          w_state_next = S_SETTLE;
        end else if (w_wd_expire) begin
          w_state_next = S_ERROR;
        end
      end
      S_SETTLE: begin
        // Second consecutive quiet cycle ends the settle window.
        if (!io_bus.leftover_inputs && r_settle_cnt == 2'd1) begin
          w_state_next = S_ACCUMULATE;
        end else if (w_wd_expire) begin
          w_state_next = S_ERROR;
        end
      end
      S_ACCUMULATE: begin
        if (io_bus.accumulate_done) begin
          w_state_next = S_DONE;
        end else if (w_wd_expire) begin
          w_state_next = S_ERROR;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset_n) begin
    if (i_reset_n) begin
      r_state       <= S_IDLE;
      r_group_cnt   <= 8'd0;
      r_sticky      <= '0;
      r_settle_cnt  <= 2'd0;
      r_wd          <= '0;
      r_error       <= 1'b0;
      r_cg_done_out <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cg_done_out <= w_accept_cg;

      if (w_accept_start) begin
        r_group_cnt <= io_bus.channel_group_count;
      end else if (w_accept_cg) begin
        r_group_cnt <= r_group_cnt - 8'd1;
      end

      if (w_state_change) begin
        r_sticky <= '0;
      end else if (r_state == S_EXCHANGE) begin
        r_sticky <= w_sticky_seen;
      end

      if (w_state_change) begin
        r_settle_cnt <= 2'd0;
      end else if (r_state == S_SETTLE) begin
        r_settle_cnt <= io_bus.leftover_inputs ? 2'd0 : r_settle_cnt + 2'd1;
      end

      if (w_state_change) begin
        r_wd <= '0;
      end else if (w_timed) begin
        r_wd <= r_wd + 1'b1;
      end

      if (w_accept_start) begin
        r_error <= 1'b0;
      end else if (w_state_next == S_ERROR && r_state != S_ERROR) begin
        r_error <= 1'b1;
      end
    end
  end

  // Read-port ownership follows the phase; the two grant windows never overlap.
  assign w_part_gnt = io_bus.part_req &&
                      (r_state == S_COMPUTE || r_state == S_EXCHANGE);
  assign w_acc_gnt  = io_bus.acc_req && (r_state == S_ACCUMULATE);

  always_ff @(posedge i_clk or posedge i_reset_n) begin
    if (i_reset_n) begin
      r_hold_bank  <= '0;
      r_hold_entry <= '0;
    end else if (w_part_gnt) begin
      r_hold_bank  <= io_bus.part_bank;
      r_hold_entry <= io_bus.part_entry;
    end else if (w_acc_gnt) begin
      r_hold_bank  <= io_bus.acc_bank;
      r_hold_entry <= io_bus.acc_entry;
    end
  end

  assign io_bus.part_gnt          = w_part_gnt;
  assign io_bus.acc_gnt           = w_acc_gnt;
  assign io_bus.buffer_bank_read  = w_part_gnt ? io_bus.part_bank :
                                    w_acc_gnt  ? io_bus.acc_bank  : r_hold_bank;
  assign io_bus.buffer_bank_entry = w_part_gnt ? io_bus.part_entry :
                                    w_acc_gnt  ? io_bus.acc_entry  : r_hold_entry;
  assign io_bus.cg_done_out       = r_cg_done_out;
  assign io_bus.acc_enable        = (r_state == S_ACCUMULATE);
  assign io_bus.phase             = r_state;
  assign io_bus.tile_done         = (r_state == S_DONE);
  assign io_bus.error             = r_error;
endmodule

// File: tb/tb_ppu_phase_sequencer.sv
// Bench for ppu_phase_sequencer: each tile is planned as a timeline of expected phases
// derived from the phase rules, then replayed cycle by cycle with random side traffic.
module tb_ppu_phase_sequencer;
  localparam int MAXC = 64;

  logic clk;
  logic rst;

  ppu_phase_sequencer_if #(.BANK_COUNT(256), .BUFFER_WIDTH(256), .NEIGHBORS(8)) bus ();

  ppu_phase_sequencer #(
    .BANK_COUNT(256), .BUFFER_WIDTH(256), .NEIGHBORS(8), .TIMEOUT_WIDTH(4)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] m_bank  = 8'd0;
  logic [7:0] m_entry = 8'd0;

  // Planned timeline of one tile, indexed by cycle offset from the start pulse.
  logic [2:0] ep_a [MAXC];
  bit         st_a [MAXC];
  bit         cg_a [MAXC];
  bit         lo_a [MAXC];
  bit         ad_a [MAXC];
  bit         td_a [MAXC];
  bit         co_a [MAXC];
  logic [8:0] ex_a [MAXC];
  int         tile_len;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_cycle(input logic [2:0] ep, input bit td, input bit co, input bit err);
    bit gp;
    bit ga;
    logic [7:0] eb;
    logic [7:0] ee;
    gp = bus.part_req && (ep == 3'd1 || ep == 3'd2);
    ga = bus.acc_req && (ep == 3'd4);
    if (gp) begin
      eb = bus.part_bank;  ee = bus.part_entry;
    end else if (ga) begin
      eb = bus.acc_bank;   ee = bus.acc_entry;
    end else begin
      eb = m_bank;         ee = m_entry;
    end
    chk("phase",       32'(bus.phase),             32'(ep));
    chk("tile_done",   32'(bus.tile_done),         32'(td));
    chk("cg_done_out", 32'(bus.cg_done_out),       32'(co));
    chk("acc_enable",  32'(bus.acc_enable),        32'(ep == 3'd4));
    chk("error",       32'(bus.error),             32'(err));
    chk("part_gnt",    32'(bus.part_gnt),          32'(gp));
    chk("acc_gnt",     32'(bus.acc_gnt),           32'(ga));
    chk("bank_addr",   32'(bus.buffer_bank_read),  32'(eb));
    chk("entry_addr",  32'(bus.buffer_bank_entry), 32'(ee));
    m_bank  = eb;
    m_entry = ee;
  endtask

  task automatic clear_inputs();
    bus.start = 1'b0;                bus.channel_group_count = 8'd0;
    bus.channel_group_done = 1'b0;   bus.exchange_done = 1'b0;
    bus.neighbor_exchange_done = '0; bus.leftover_inputs = 1'b0;
    bus.accumulate_done = 1'b0;
    bus.part_req = 1'b0; bus.part_bank = 8'd0; bus.part_entry = 8'd0;
    bus.acc_req  = 1'b0; bus.acc_bank  = 8'd0; bus.acc_entry  = 8'd0;
  endtask

  task automatic begin_cycle();
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic end_cycle(input logic [2:0] ep, input bit td, input bit co, input bit err);
    @(negedge clk);
    check_cycle(ep, td, co, err);
  endtask

  // mode 0: random gaps/noise; 1: minimum latency; 2: staggered exchange with a
  // one-cycle neighbor-5 pulse and leftover pattern 0,1,0,0.
  task automatic plan_tile(input int n, input int mode);
    int c, e, a, amax, t, k, u, f, idx;
    bit pulse;
    for (int i = 0; i < MAXC; i++) begin
      ep_a[i] = 3'd0; st_a[i] = 1'b0; cg_a[i] = 1'b0; ad_a[i] = 1'b0;
      td_a[i] = 1'b0; co_a[i] = 1'b0; ex_a[i] = 9'd0;
      lo_a[i] = (mode == 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
    end
    st_a[0] = 1'b1;
    if (n == 0) begin
      ep_a[1] = 3'd5; td_a[1] = 1'b1; tile_len = 3;
      return;
    end
    if (mode == 0) cg_a[0] = ($urandom_range(0, 1) == 1);
    c = 1 + ((mode == 0) ? int'($urandom_range(0, 2)) : 0);
    for (int g = 0; g < n; g++) begin
      if (g > 0) c = c + ((mode == 0) ? int'($urandom_range(1, 3)) : 1);
      cg_a[c] = 1'b1;
      co_a[c+1] = 1'b1;
    end
    for (int i = 1; i <= c; i++) begin
      ep_a[i] = 3'd1;
      if (mode == 0 && $urandom_range(0, 3) == 0) begin
        idx = int'($urandom_range(0, 8));
        ex_a[i] = ex_a[i] | (9'd1 << idx);
      end
    end
    e = c + 1;
    amax = e;
    for (int j = 0; j < 9; j++) begin
      if (mode == 0) begin
        a = e + int'($urandom_range(0, 5));
        pulse = ($urandom_range(0, 1) == 1);
      end else if (mode == 1) begin
        a = e; pulse = 1'b0;
      end else begin
        a = (j == 6) ? e : e + 3 + (j % 3);
        pulse = (j == 6);
      end
      if (pulse) ex_a[a] = ex_a[a] | (9'd1 << j);
      else for (int i = a; i < MAXC; i++) ex_a[i] = ex_a[i] | (9'd1 << j);
      if (a > amax) amax = a;
    end
    for (int i = e; i <= amax; i++) ep_a[i] = 3'd2;
    t = amax + 1;
    if (mode == 2) begin
      lo_a[t] = 1'b0; lo_a[t+1] = 1'b1; lo_a[t+2] = 1'b0; lo_a[t+3] = 1'b0;
    end
    for (int i = t + 4; i < MAXC; i++) lo_a[i] = 1'b0;
    k = t + 1;
    while (lo_a[k-1] || lo_a[k]) k++;
    for (int i = t; i <= k; i++) ep_a[i] = 3'd3;
    u = k + 1;
    f = u + ((mode == 0) ? int'($urandom_range(0, 4)) : 0);
    if (mode == 0) begin
      for (int i = 1; i < u; i++) ad_a[i] = ($urandom_range(0, 5) == 0);
      for (int i = e; i <= f + 1; i++) cg_a[i] = cg_a[i] | ($urandom_range(0, 3) == 0);
      for (int i = 1; i <= f + 1; i++) st_a[i] = ($urandom_range(0, 7) == 0);
    end
    ad_a[f] = 1'b1;
    for (int i = u; i <= f; i++) ep_a[i] = 3'd4;
    ep_a[f+1] = 3'd5;
    td_a[f+1] = 1'b1;
    tile_len = f + 3;
  endtask

  task automatic play_tile(input int n);
    for (int i = 0; i < tile_len; i++) begin
      @(posedge clk); #1;
      bus.start                  = st_a[i];
      bus.channel_group_count    = (i == 0) ? 8'(n) : 8'($urandom_range(0, 255));
      bus.channel_group_done     = cg_a[i];
      bus.exchange_done          = ex_a[i][0];
      bus.neighbor_exchange_done = ex_a[i][8:1];
      bus.leftover_inputs        = lo_a[i];
      bus.accumulate_done        = ad_a[i];
      bus.part_req   = ($urandom_range(0, 1) == 1);
      bus.part_bank  = 8'($urandom_range(0, 255));
      bus.part_entry = 8'($urandom_range(0, 255));
      bus.acc_req    = ($urandom_range(0, 1) == 1);
      bus.acc_bank   = 8'($urandom_range(0, 255));
      bus.acc_entry  = 8'($urandom_range(0, 255));
      @(negedge clk);
      check_cycle(ep_a[i], td_a[i], co_a[i], 1'b0);
      $display("tile n=%0d cyc=%0d phase=%0d exp=%0d tile_done=%0d", n, i,
               bus.phase, ep_a[i], bus.tile_done);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    check_cycle(3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    plan_tile(1, 1); play_tile(1);
    plan_tile(3, 2); play_tile(3);
    plan_tile(0, 0); play_tile(0);
    for (int r = 0; r < 12; r++) begin
      n = int'($urandom_range(0, 4));
      plan_tile(n, 0); play_tile(n);
    end

    // Watchdog: local sender never reports, so EXCHANGE lasts 15 cycles then ERROR.
    begin_cycle(); bus.start = 1'b1; bus.channel_group_count = 8'd1;
    end_cycle(3'd0, 1'b0, 1'b0, 1'b0);
    begin_cycle(); bus.channel_group_done = 1'b1;
    end_cycle(3'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      begin_cycle(); bus.neighbor_exchange_done = '1;
      if (i == 0) begin
        bus.part_req = 1'b1; bus.part_bank = 8'h3c; bus.part_entry = 8'h77;
      end
      end_cycle(3'd2, 1'b0, i == 0, 1'b0);
    end
    begin_cycle(); bus.part_req = 1'b1; bus.acc_req = 1'b1;
    bus.part_bank = 8'h01; bus.part_entry = 8'h02; bus.acc_bank = 8'h03; bus.acc_entry = 8'h04;
    end_cycle(3'd6, 1'b0, 1'b0, 1'b1);
    chk("wd_hold_bank", 32'(bus.buffer_bank_read), 32'h3c);
    begin_cycle(); bus.start = 1'b1; bus.channel_group_count = 8'd0;
    end_cycle(3'd6, 1'b0, 1'b0, 1'b1);
    begin_cycle();
    end_cycle(3'd5, 1'b1, 1'b0, 1'b0);
    begin_cycle(); bus.part_req = 1'b1; bus.acc_req = 1'b1;
    bus.part_bank = 8'h55; bus.part_entry = 8'h66; bus.acc_bank = 8'h77; bus.acc_entry = 8'h88;
    end_cycle(3'd0, 1'b0, 1'b0, 1'b0);
    $display("watchdog sequence done error=%0d phase=%0d", bus.error, bus.phase);

    // Reset asserted during ACCUMULATE aborts to IDLE with no tile_done.
    begin_cycle(); bus.start = 1'b1; bus.channel_group_count = 8'd1;
    end_cycle(3'd0, 1'b0, 1'b0, 1'b0);
    begin_cycle(); bus.channel_group_done = 1'b1;
    end_cycle(3'd1, 1'b0, 1'b0, 1'b0);
    begin_cycle(); bus.exchange_done = 1'b1; bus.neighbor_exchange_done = '1;
    end_cycle(3'd2, 1'b0, 1'b1, 1'b0);
    begin_cycle(); end_cycle(3'd3, 1'b0, 1'b0, 1'b0);
    begin_cycle(); end_cycle(3'd3, 1'b0, 1'b0, 1'b0);
    begin_cycle(); bus.acc_req = 1'b1; bus.acc_bank = 8'h11; bus.acc_entry = 8'h22;
    end_cycle(3'd4, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    m_bank = 8'd0; m_entry = 8'd0;
    check_cycle(3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_cycle(3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      begin_cycle(); bus.accumulate_done = 1'b1; bus.acc_req = 1'b1;
      end_cycle(3'd0, 1'b0, 1'b0, 1'b0);
    end
    $display("reset abort sequence done phase=%0d tile_done=%0d", bus.phase, bus.tile_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
